// File: rtl/systolic_result_drain.sv
// Output-side drain for a 1xNUM_PE systolic row: captures each PE's final
// accumulator value on its skewed cycle, then streams the words out over valid/ready.
module systolic_result_drain #(
  parameter int OUTPUT_WIDTH = 12,
  parameter int NUM_PE       = 16,
  parameter int K_LEN        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_PE*OUTPUT_WIDTH-1:0] pe_flat,
  output logic [OUTPUT_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_PE)-1:0]      out_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int IW = $clog2(NUM_PE);
  localparam int TW = $clog2(K_LEN + NUM_PE) + 1;
  localparam logic [TW-1:0] T_LAST   = TW'(K_LEN + NUM_PE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PE - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                          state_q;
  logic [TW-1:0]                   t_q;
  logic [OUTPUT_WIDTH-1:0]         out_data_q;
  logic [IW-1:0]                   out_index_q;
  logic                            out_valid_q;
  logic                            out_last_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            overrun_q;

  logic [NUM_PE*OUTPUT_WIDTH-1:0]  shadow_flat;
  logic [NUM_PE*OUTPUT_WIDTH-1:0]  shadow_d_flat;
  logic [IW-1:0]                   next_idx;
  logic [OUTPUT_WIDTH-1:0]         next_word;

  // PE gi's result is final K_LEN+gi cycles into the pass, one cycle later per PE.
  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : gen_shadow
      logic [OUTPUT_WIDTH-1:0] shadow_q;
      logic [OUTPUT_WIDTH-1:0] shadow_d;

      always_comb begin
        shadow_d = shadow_q;
        if (state_q == ACCUM && t_q == TW'(K_LEN + gi))
          shadow_d = pe_flat[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= '0;
        else     shadow_q <= shadow_d;
      end

      assign shadow_flat[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH]   = shadow_q;
      assign shadow_d_flat[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = shadow_d;
    end
  endgenerate

  always_comb begin
    next_idx  = out_index_q + 1'b1;
    next_word = shadow_flat[next_idx*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && state_q != IDLE)
        overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCUM;
            // Counter restarts from zero; the first ACCUM cycle already counts as t=1.
            t_q     <= TW'(1);
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          t_q <= t_q + 1'b1;
          if (t_q == T_LAST) begin
            state_q     <= DRAIN;
            out_valid_q <= 1'b1;
            out_index_q <= '0;
            out_data_q  <= shadow_d_flat[0 +: OUTPUT_WIDTH];
            out_last_q  <= (NUM_PE == 1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_index_q == IDX_LAST) begin
              state_q     <= IDLE;
              t_q         <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_index_q <= '0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_index_q <= next_idx;
              out_data_q  <= next_word;
              out_last_q  <= (next_idx == IDX_LAST);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: timing of capture, drain, handshake,
// overrun and reset behaviour with hand-computed expected cycles and words.
module tb_systolic_result_drain;

  localparam int OW = 12;
  localparam int NP = 16;
  localparam int KL = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NP*OW-1:0] pe_flat;
  logic [OW-1:0]   out_data;
  logic [3:0]      out_index;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            overrun;

  int checks = 0;
  int errors = 0;
  int pass_no = 0;

  systolic_result_drain #(.OUTPUT_WIDTH(OW), .NUM_PE(NP), .K_LEN(KL)) dut (
    .clk(clk), .rst(rst), .start(start), .pe_flat(pe_flat),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pass starting in the current cycle (cycle 0) and checks every cycle
  // through the done pulse. mode 0: ready always high; mode 1: ready 1,0,0,1,0,0...
  task automatic run_pass(input logic [OW-1:0] base, input bit skew, input int mode,
                          input bit second_start, input bit exp_ovr, output int hs_cycle);
    int k;
    bit exp_valid, exp_done, exp_ovr_now;
    k = 0;
    hs_cycle = -1;
    pass_no++;
    start = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++)
      pe_flat[i*OW +: OW] = skew ? '0 : base + OW'(i);
    for (int c = 1; c < 200; c++) begin
      tick();
      start = second_start && (c == 10);
      if (skew) begin
        pe_flat = '0;
        if (c >= KL && c < KL + NP) pe_flat[(c-KL)*OW +: OW] = base + OW'(c - KL);
      end
      if (mode == 1 && c >= KL + NP) out_ready = ((c - (KL + NP)) % 3) == 0;
      else out_ready = 1'b1;
      exp_valid   = (c >= KL + NP) && (k < NP);
      exp_done    = (hs_cycle >= 0) && (c == hs_cycle + 1);
      exp_ovr_now = exp_ovr || (second_start && c >= 11);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL valid pass=%0d cyc=%0d got=%b exp=%b", pass_no, c, out_valid, exp_valid);
      end
      checks++;
      if (busy !== (k < NP)) begin
        errors++;
        $display("FAIL busy pass=%0d cyc=%0d got=%b exp=%b", pass_no, c, busy, (k < NP));
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done pass=%0d cyc=%0d got=%b exp=%b", pass_no, c, done, exp_done);
      end
      checks++;
      if (overrun !== exp_ovr_now) begin
        errors++;
        $display("FAIL overrun pass=%0d cyc=%0d got=%b exp=%b", pass_no, c, overrun, exp_ovr_now);
      end
      checks++;
      if (out_last !== (exp_valid && k == NP - 1)) begin
        errors++;
        $display("FAIL last pass=%0d cyc=%0d got=%b exp=%b", pass_no, c, out_last,
                 (exp_valid && k == NP - 1));
      end
      if (exp_valid) begin
        checks++;
        if (out_data !== base + OW'(k) || out_index !== 4'(k)) begin
          errors++;
          $display("FAIL word pass=%0d cyc=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                   pass_no, c, out_index, out_data, k, base + OW'(k));
        end
        if (out_ready) begin
          $display("pass %0d cyc %0d handshake idx=%0d data=%h last=%b",
                   pass_no, c, out_index, out_data, out_last);
          k++;
          if (k == NP) hs_cycle = c;
        end
      end
      if (exp_done) begin
        start = 1'b0;
        return;
      end
    end
    errors++;
    $display("FAIL timeout pass=%0d words=%0d exp=%0d", pass_no, k, NP);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pe_flat = '0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({out_data, out_index, out_valid, out_last, busy, done, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_state got data=%h idx=%0d v=%b l=%b b=%b d=%b o=%b exp all 0",
               out_data, out_index, out_valid, out_last, busy, done, overrun);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b valid=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int hs;
    run_pass(12'h100, 1'b0, 0, 1'b0, 1'b0, hs);
    checks++;
    if (hs !== 47) begin
      errors++;
      $display("FAIL basic_last_hs got=%0d exp=47", hs);
    end
    tick();
  endtask

  task automatic test_skew_capture();
    int hs;
    run_pass(12'h200, 1'b1, 0, 1'b0, 1'b0, hs);
    tick();
  endtask

  task automatic test_backpressure();
    int hs;
    run_pass(12'h0A0, 1'b0, 1, 1'b0, 1'b0, hs);
    checks++;
    if (hs !== 77) begin
      errors++;
      $display("FAIL bp_last_hs got=%0d exp=77", hs);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int hs;
    run_pass(12'h100, 1'b0, 0, 1'b0, 1'b0, hs);
    run_pass(12'h150, 1'b0, 0, 1'b0, 1'b0, hs);
    checks++;
    if (hs !== 47) begin
      errors++;
      $display("FAIL b2b_last_hs got=%0d exp=47", hs);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    int hs;
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < NP; i++) pe_flat[i*OW +: OW] = 12'h3C0 + OW'(i);
    for (int c = 1; c <= 36; c++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1 || out_index !== 4'd4 || out_data !== 12'h3C4) begin
      errors++;
      $display("FAIL pre_reset got v=%b idx=%0d data=%h exp 1 4 3c4", out_valid, out_index, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_data, out_index, out_valid, out_last, busy, done, overrun} !== '0) begin
      errors++;
      $display("FAIL async_reset got data=%h idx=%0d v=%b l=%b b=%b d=%b o=%b exp all 0",
               out_data, out_index, out_valid, out_last, busy, done, overrun);
    end
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet cyc=%0d got d=%b v=%b b=%b exp 0 0 0", c, done, out_valid, busy);
      end
    end
    run_pass(12'h3C0, 1'b0, 0, 1'b0, 1'b0, hs);
    tick();
  endtask

  task automatic test_overrun();
    int hs;
    run_pass(12'h100, 1'b0, 0, 1'b1, 1'b0, hs);
    checks++;
    if (hs !== 47) begin
      errors++;
      $display("FAIL overrun_pass_hs got=%0d exp=47", hs);
    end
    tick();
    run_pass(12'h1A0, 1'b0, 0, 1'b0, 1'b1, hs);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got=%b exp=0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew_capture();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
